// File: rtl/multicycle_maindec_if.sv
// Control and handshake bundle between the multi-cycle main decoder and the datapath.
interface multicycle_maindec_if #(
  parameter int OP_W  = 11,
  parameter int RET_W = 16
);
  logic [OP_W-1:0]  Op;
  logic             mem_ready;

  logic             PCWrite;
  logic             IRWrite;
  logic             Reg2Loc;
  logic             ALUSrc;
  logic             MemtoReg;
  logic             RegWrite;
  logic             MemRead;
  logic             MemWrite;
  logic             Branch;
  logic             BranchInv;
  logic             UncondBranch;
  logic [1:0]       ALUOp;

  logic             instr_done;
  logic             illegal_op;
  logic             bus_err;
  logic [RET_W-1:0] retired;

  // Decoder side: consumes opcode and memory handshake, drives the control set.
  modport master (
    input  Op, mem_ready,
    output PCWrite, IRWrite, Reg2Loc, ALUSrc, MemtoReg, RegWrite, MemRead, MemWrite,
           Branch, BranchInv, UncondBranch, ALUOp, instr_done, illegal_op, bus_err, retired
  );

  // Datapath side: supplies opcode and memory handshake, receives the control set.
  modport slave (
    output Op, mem_ready,
    input  PCWrite, IRWrite, Reg2Loc, ALUSrc, MemtoReg, RegWrite, MemRead, MemWrite,
           Branch, BranchInv, UncondBranch, ALUOp, instr_done, illegal_op, bus_err, retired
  );
endinterface

// File: rtl/multicycle_maindec.sv
// Multi-cycle LEGv8 main control FSM with memory-wait timeout, trap flags and retire counter.
//
//   state   | meaning
//   --------+--------------------------------------------------------------
//   RST     | post-reset idle, all outputs low
//   FETCH   | instruction read; IR/PC load when memory is ready
//   DECODE  | classify Op and latch the instruction class
//   EX_R    | R-type ALU operation
//   WB_R    | R-type register write-back, instruction completes
//   EX_MEM  | address generation for LDUR/STUR
//   MEM_LD  | data read, waits for memory
//   MEM_ST  | data write, waits for memory, instruction completes
//   WB_LD   | load write-back, instruction completes
//   EX_BR   | branch evaluation (CBZ/CBNZ/B), instruction completes
//   TRAP    | illegal opcode or memory timeout, held until reset
module multicycle_maindec #(
  parameter int OP_W    = 11,
  parameter bit EXT_OPS = 1'b1,
  parameter int TMO_W   = 4,
  parameter int RET_W   = 16
) (
  input logic                  clk,
  input logic                  reset_n,
  multicycle_maindec_if.master bus
);

  typedef enum logic [3:0] {
    S_RST, S_FETCH, S_DECODE, S_EX_R, S_WB_R, S_EX_MEM,
    S_MEM_LD, S_MEM_ST, S_WB_LD, S_EX_BR, S_TRAP
  } state_e;

  typedef enum logic [2:0] {
    C_NONE, C_LDUR, C_STUR, C_RTYPE, C_CBZ, C_CBNZ, C_B
  } cls_e;

  // The timer traps when it would reach all-ones, i.e. on the cycle it holds all-ones minus one.
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'((2 ** TMO_W) - 2);

  state_e           state_q, state_d;
  cls_e             cls_q, cls_d;
  cls_e             op_cls;
  logic [TMO_W-1:0] timer_q, timer_d;
  logic             illegal_q, illegal_d;
  logic             bus_err_q, bus_err_d;
  logic [RET_W-1:0] retired_q, retired_d;
  logic             wait_st;
  logic             tmo_hit;
  logic             done;

  // Opcode classification; only consumed while in DECODE.
  always_comb begin
    op_cls = C_NONE;
    casez (bus.Op)
      11'b11111000010: op_cls = C_LDUR;
      11'b11111000000: op_cls = C_STUR;
      11'b10110100???: op_cls = C_CBZ;
      11'b10001011000,
      11'b11001011000,
      11'b10001010000,
      11'b10101010000: op_cls = C_RTYPE;
      11'b10110101???: if (EXT_OPS) op_cls = C_CBNZ;
      11'b000101?????: if (EXT_OPS) op_cls = C_B;
      default:         op_cls = C_NONE;
    endcase
  end

  // Memory-wait timer: runs only while a memory-facing state sees mem_ready low.
  always_comb begin
    wait_st = (state_q == S_FETCH) || (state_q == S_MEM_LD) || (state_q == S_MEM_ST);
    tmo_hit = wait_st && !bus.mem_ready && (timer_q == TMO_LAST);
    timer_d = (wait_st && !bus.mem_ready) ? timer_q + 1'b1 : '0;
  end

  // Retired-instruction counter advances on each completion pulse and wraps naturally.
  always_comb begin
    retired_d = retired_q + {{(RET_W-1){1'b0}}, done};
  end

  // State, latched class, timer, sticky flags and retire count.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= S_RST;
      cls_q     <= C_NONE;
      timer_q   <= '0;
      illegal_q <= 1'b0;
      bus_err_q <= 1'b0;
      retired_q <= '0;
    end else begin
      state_q   <= state_d;
      cls_q     <= cls_d;
      timer_q   <= timer_d;
      illegal_q <= illegal_d;
      bus_err_q <= bus_err_d;
      retired_q <= retired_d;
    end
  end

  // Next-state selection; a ready memory beats a timeout on the same cycle.
  always_comb begin
    state_d   = state_q;
    cls_d     = cls_q;
    illegal_d = illegal_q;
    bus_err_d = bus_err_q;
    unique case (state_q)
      S_RST:    state_d = S_FETCH;
      S_FETCH: begin
        if (bus.mem_ready) begin
          state_d = S_DECODE;
        end else if (tmo_hit) begin
          state_d   = S_TRAP;
          bus_err_d = 1'b1;
        end
      end
      S_DECODE: begin
        cls_d = op_cls;
        unique case (op_cls)
          C_LDUR, C_STUR:    state_d = S_EX_MEM;
          C_RTYPE:           state_d = S_EX_R;
          C_CBZ, C_CBNZ, C_B: state_d = S_EX_BR;
          default: begin
            state_d   = S_TRAP;
            illegal_d = 1'b1;
          end
        endcase
      end
      S_EX_R:   state_d = S_WB_R;
      S_WB_R:   state_d = S_FETCH;
      S_EX_MEM: state_d = (cls_q == C_LDUR) ? S_MEM_LD : S_MEM_ST;
      S_MEM_LD: begin
        if (bus.mem_ready) begin
          state_d = S_WB_LD;
        end else if (tmo_hit) begin
          state_d   = S_TRAP;
          bus_err_d = 1'b1;
        end
      end
      S_WB_LD:  state_d = S_FETCH;
      S_MEM_ST: begin
        if (bus.mem_ready) begin
          state_d = S_FETCH;
        end else if (tmo_hit) begin
          state_d   = S_TRAP;
          bus_err_d = 1'b1;
        end
      end
      S_EX_BR:  state_d = S_FETCH;
      S_TRAP:   state_d = S_TRAP;
      default:  state_d = S_TRAP;
    endcase
  end

  // Control outputs from state and latched class; FETCH/MEM_ST completions qualify on mem_ready.
  always_comb begin
    bus.PCWrite      = 1'b0;
    bus.IRWrite      = 1'b0;
    bus.Reg2Loc      = 1'b0;
    bus.ALUSrc       = 1'b0;
    bus.MemtoReg     = 1'b0;
    bus.RegWrite     = 1'b0;
    bus.MemRead      = 1'b0;
    bus.MemWrite     = 1'b0;
    bus.Branch       = 1'b0;
    bus.BranchInv    = 1'b0;
    bus.UncondBranch = 1'b0;
    bus.ALUOp        = 2'b00;
    done             = 1'b0;
    unique case (state_q)
      S_FETCH: begin
        bus.MemRead = 1'b1;
        bus.IRWrite = bus.mem_ready;
        bus.PCWrite = bus.mem_ready;
      end
      S_DECODE: begin
        // Class is not latched yet, so register-port select follows the live opcode.
        bus.Reg2Loc = (op_cls == C_STUR) || (op_cls == C_CBZ) || (op_cls == C_CBNZ);
      end
      S_EX_R: begin
        bus.ALUOp = 2'b10;
      end
      S_WB_R: begin
        bus.RegWrite = 1'b1;
        done         = 1'b1;
      end
      S_EX_MEM: begin
        bus.ALUSrc = 1'b1;
      end
      S_MEM_LD: begin
        bus.MemRead = 1'b1;
      end
      S_WB_LD: begin
        bus.RegWrite = 1'b1;
        bus.MemtoReg = 1'b1;
        done         = 1'b1;
      end
      S_MEM_ST: begin
        bus.MemWrite = 1'b1;
        bus.Reg2Loc  = 1'b1;
        done         = bus.mem_ready;
      end
      S_EX_BR: begin
        // PC load is requested here; the datapath qualifies it with the branch condition.
        bus.ALUOp        = 2'b01;
        bus.Branch       = 1'b1;
        bus.PCWrite      = 1'b1;
        bus.BranchInv    = (cls_q == C_CBNZ);
        bus.UncondBranch = (cls_q == C_B);
        done             = 1'b1;
      end
      default: ;
    endcase
  end

  assign bus.instr_done = done;
  assign bus.illegal_op = illegal_q;
  assign bus.bus_err    = bus_err_q;
  assign bus.retired    = retired_q;

endmodule

// File: tb/tb_multicycle_maindec.sv
// Bench for multicycle_maindec: scoreboarded random instruction stream plus directed trap/reset cases.
module tb_multicycle_maindec;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_main_n;
  logic rst_aux_n;

  // Main instance: extended ops on, 7-cycle timeout, 2-bit retire counter.
  multicycle_maindec_if #(.OP_W(11), .RET_W(2)) bus_m ();
  multicycle_maindec #(.OP_W(11), .EXT_OPS(1'b1), .TMO_W(3), .RET_W(2)) u_main (
    .clk(clk), .reset_n(rst_main_n), .bus(bus_m)
  );

  // Aux instance: extended ops off, 3-cycle timeout.
  multicycle_maindec_if #(.OP_W(11), .RET_W(16)) bus_a ();
  multicycle_maindec #(.OP_W(11), .EXT_OPS(1'b0), .TMO_W(2), .RET_W(16)) u_aux (
    .clk(clk), .reset_n(rst_aux_n), .bus(bus_a)
  );

  localparam int K_ILL = 0, K_R = 1, K_LD = 2, K_ST = 3, K_CBZ = 4, K_CBNZ = 5, K_B = 6;

  typedef struct packed {
    logic [7:0] rd, wr, rw, m2r, r2l, alusrc, br, inv, unc, alu10, alu01, irw, pcw, both, done_rw;
  } prof_t;

  typedef struct {
    int    cyc;
    int    ret;
    prof_t p;
  } exp_t;

  exp_t exp_q[$];
  int   checks   = 0;
  int   failures = 0;
  int   model_ret = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, req);
    end
  endtask

  function automatic logic [13:0] ctrl_m();
    return {bus_m.PCWrite, bus_m.IRWrite, bus_m.Reg2Loc, bus_m.ALUSrc, bus_m.MemtoReg,
            bus_m.RegWrite, bus_m.MemRead, bus_m.MemWrite, bus_m.Branch, bus_m.BranchInv,
            bus_m.UncondBranch, bus_m.ALUOp, bus_m.instr_done};
  endfunction

  function automatic logic [13:0] ctrl_a();
    return {bus_a.PCWrite, bus_a.IRWrite, bus_a.Reg2Loc, bus_a.ALUSrc, bus_a.MemtoReg,
            bus_a.RegWrite, bus_a.MemRead, bus_a.MemWrite, bus_a.Branch, bus_a.BranchInv,
            bus_a.UncondBranch, bus_a.ALUOp, bus_a.instr_done};
  endfunction

  function automatic logic [7:0] inc(input logic [7:0] v, input logic b);
    return v + {7'd0, b};
  endfunction

  function automatic logic [10:0] make_op(input int kind);
    logic [10:0] r;
    logic [10:0] rops [4];
    r = 11'($urandom);
    rops[0] = 11'b10001011000;
    rops[1] = 11'b11001011000;
    rops[2] = 11'b10001010000;
    rops[3] = 11'b10101010000;
    case (kind)
      K_R:     return rops[$urandom_range(0, 3)];
      K_LD:    return 11'b11111000010;
      K_ST:    return 11'b11111000000;
      K_CBZ:   return {8'b10110100, r[2:0]};
      K_CBNZ:  return {8'b10110101, r[2:0]};
      K_B:     return {6'b000101, r[4:0]};
      default: return 11'b00000000000;
    endcase
  endfunction

  // Reference: per-instruction cycle count and control-activity profile from the sequencing rules.
  function automatic exp_t model(input int kind, input int fw, input int mw, input int ret);
    exp_t e;
    bit is_br;
    is_br    = (kind == K_CBZ) || (kind == K_CBNZ) || (kind == K_B);
    e.ret    = ret;
    e.p      = '0;
    case (kind)
      K_R:     e.cyc = fw + 4;
      K_LD:    e.cyc = fw + mw + 5;
      K_ST:    e.cyc = fw + mw + 4;
      default: e.cyc = fw + 3;
    endcase
    e.p.rd      = 8'(fw + 1 + ((kind == K_LD) ? mw + 1 : 0));
    e.p.wr      = 8'((kind == K_ST) ? mw + 1 : 0);
    e.p.rw      = 8'((kind == K_R || kind == K_LD) ? 1 : 0);
    e.p.done_rw = e.p.rw;
    e.p.m2r     = 8'((kind == K_LD) ? 1 : 0);
    e.p.r2l     = 8'((kind == K_ST) ? mw + 2 : ((kind == K_CBZ || kind == K_CBNZ) ? 1 : 0));
    e.p.alusrc  = 8'((kind == K_LD || kind == K_ST) ? 1 : 0);
    e.p.br      = 8'(is_br ? 1 : 0);
    e.p.inv     = 8'((kind == K_CBNZ) ? 1 : 0);
    e.p.unc     = 8'((kind == K_B) ? 1 : 0);
    e.p.alu10   = 8'((kind == K_R) ? 1 : 0);
    e.p.alu01   = 8'(is_br ? 1 : 0);
    e.p.irw     = 8'd1;
    e.p.pcw     = 8'(is_br ? 2 : 1);
    e.p.both    = 8'd0;
    return e;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic rnd_ready_m();
    bus_m.mem_ready = 1'($urandom_range(0, 1));
  endtask

  // Drives one instruction on the main instance, cycle by cycle, after queuing its expectation.
  task automatic run_instr(input int kind, input int fw, input int mw);
    logic [10:0] op;
    op = make_op(kind);
    exp_q.push_back(model(kind, fw, mw, model_ret));
    model_ret = (model_ret + 1) % 4;
    repeat (fw) begin
      bus_m.Op = 11'($urandom); bus_m.mem_ready = 1'b0; step();
    end
    bus_m.Op = 11'($urandom); bus_m.mem_ready = 1'b1; step();
    bus_m.Op = op; rnd_ready_m(); step();
    bus_m.Op = 11'($urandom);
    case (kind)
      K_R: begin
        rnd_ready_m(); step();
        rnd_ready_m(); step();
      end
      K_LD: begin
        rnd_ready_m(); step();
        repeat (mw) begin bus_m.mem_ready = 1'b0; step(); end
        bus_m.mem_ready = 1'b1; step();
        rnd_ready_m(); step();
      end
      K_ST: begin
        rnd_ready_m(); step();
        repeat (mw) begin bus_m.mem_ready = 1'b0; step(); end
        bus_m.mem_ready = 1'b1; step();
      end
      default: begin
        rnd_ready_m(); step();
      end
    endcase
  endtask

  task automatic reset_main();
    rst_main_n = 1'b0;
    bus_m.Op = 11'($urandom);
    bus_m.mem_ready = 1'b0;
    step(); step();
    chk("main_reset_ctrl", ctrl_m(), 14'd0);
    chk("main_reset_status", {bus_m.retired, bus_m.illegal_op, bus_m.bus_err}, 4'd0);
    exp_q.delete();
    model_ret = 0;
    rst_main_n = 1'b1;
    step();
  endtask

  // Monitor: profiles main-instance outputs and scores each completed instruction.
  prof_t acc;
  int    cyc;
  bit    started;
  exp_t  e_mon;
  always @(negedge clk) begin
    if (!rst_main_n) begin
      started = 1'b0;
      cyc     = 0;
      acc     = '0;
    end else begin
      if (!started && bus_m.MemRead) started = 1'b1;
      if (started) begin
        cyc++;
        acc.rd     = inc(acc.rd, bus_m.MemRead);
        acc.wr     = inc(acc.wr, bus_m.MemWrite);
        acc.rw     = inc(acc.rw, bus_m.RegWrite);
        acc.m2r    = inc(acc.m2r, bus_m.MemtoReg);
        acc.r2l    = inc(acc.r2l, bus_m.Reg2Loc);
        acc.alusrc = inc(acc.alusrc, bus_m.ALUSrc);
        acc.br     = inc(acc.br, bus_m.Branch);
        acc.inv    = inc(acc.inv, bus_m.BranchInv);
        acc.unc    = inc(acc.unc, bus_m.UncondBranch);
        acc.alu10  = inc(acc.alu10, bus_m.ALUOp == 2'b10);
        acc.alu01  = inc(acc.alu01, bus_m.ALUOp == 2'b01);
        acc.irw    = inc(acc.irw, bus_m.IRWrite);
        acc.pcw    = inc(acc.pcw, bus_m.PCWrite);
        acc.both   = inc(acc.both, bus_m.MemRead && bus_m.MemWrite);
        if (bus_m.instr_done) begin
          acc.done_rw = {7'd0, bus_m.RegWrite};
          if (exp_q.size() == 0) begin
            chk("unexpected_done", 1'b1, 1'b0);
          end else begin
            e_mon = exp_q.pop_front();
            chk("instr_cycles", 128'(cyc), 128'(e_mon.cyc));
            chk("instr_profile", acc, e_mon.p);
            chk("retired_at_done", bus_m.retired, 128'(e_mon.ret));
          end
          cyc = 0;
          acc = '0;
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog time limit reached checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

  initial begin
    int kinds[$];
    rst_main_n = 1'b0;
    rst_aux_n  = 1'b0;
    bus_m.Op = '0; bus_m.mem_ready = 1'b0;
    bus_a.Op = '0; bus_a.mem_ready = 1'b0;

    // Main instance: directed sequence then random stream.
    reset_main();
    run_instr(K_R, 0, 0);
    run_instr(K_LD, 0, 3);
    run_instr(K_ST, 0, 0);
    run_instr(K_CBZ, 0, 0);
    chk("retired_wrap_after_4", bus_m.retired, 2'd0);
    run_instr(K_CBNZ, 1, 0);
    run_instr(K_B, 0, 0);
    run_instr(K_LD, 6, 6);
    run_instr(K_ST, 6, 6);
    for (int i = 0; i < 40; i++) begin
      run_instr($urandom_range(K_R, K_B), $urandom_range(0, 6), $urandom_range(0, 6));
    end
    chk("queue_drained", 128'(exp_q.size()), 128'd0);

    // Async reset while a store is waiting in MEM_ST.
    bus_m.mem_ready = 1'b1; bus_m.Op = 11'($urandom); step();
    bus_m.Op = 11'b11111000000; step();
    bus_m.Op = 11'($urandom); step();
    bus_m.mem_ready = 1'b0;
    #1;
    chk("mem_st_write_before_reset", bus_m.MemWrite, 1'b1);
    #2 rst_main_n = 1'b0;
    #1;
    chk("mem_st_write_async_drop", {bus_m.MemWrite, bus_m.RegWrite, bus_m.Reg2Loc}, 3'b000);
    chk("retired_async_clear", bus_m.retired, 2'd0);
    reset_main();

    // Undecodable opcode traps and freezes outputs.
    bus_m.mem_ready = 1'b1; bus_m.Op = 11'($urandom); step();
    bus_m.Op = 11'b00000000000; step();
    chk("illegal_flag", {bus_m.illegal_op, bus_m.bus_err}, 2'b10);
    for (int i = 0; i < 4; i++) begin
      bus_m.Op = 11'($urandom); rnd_ready_m(); step();
      chk("trap_ctrl_quiet", ctrl_m(), 14'd0);
    end
    chk("trap_retired_held", bus_m.retired, 2'd0);
    chk("trap_illegal_sticky", bus_m.illegal_op, 1'b1);

    // Aux instance: ready on the last allowed wait cycle completes normally.
    rst_aux_n = 1'b0;
    step(); step();
    chk("aux_reset_ctrl", ctrl_a(), 14'd0);
    rst_aux_n = 1'b1;
    step();
    bus_a.mem_ready = 1'b0; step(); step();
    chk("aux_wait2_no_trap", {bus_a.MemRead, bus_a.bus_err}, 2'b10);
    bus_a.mem_ready = 1'b1; step();
    bus_a.Op = 11'b10001011000; step();
    bus_a.Op = 11'($urandom); step();
    chk("aux_wb_r", {bus_a.instr_done, bus_a.RegWrite, bus_a.MemtoReg}, 3'b110);
    step();
    chk("aux_retired_one", bus_a.retired, 16'd1);

    // Aux instance: three not-ready cycles in FETCH times out.
    bus_a.mem_ready = 1'b0; step(); step();
    chk("aux_tmo_not_yet", {bus_a.MemRead, bus_a.bus_err}, 2'b10);
    step();
    chk("aux_tmo_bus_err", {bus_a.bus_err, bus_a.illegal_op}, 2'b10);
    chk("aux_tmo_ctrl_quiet", ctrl_a(), 14'd0);
    bus_a.mem_ready = 1'b1; step(); step();
    chk("aux_tmo_held", {ctrl_a(), bus_a.bus_err}, 15'd1);
    chk("aux_tmo_retired_held", bus_a.retired, 16'd1);

    // Aux instance: B is illegal without extended ops.
    rst_aux_n = 1'b0;
    step();
    rst_aux_n = 1'b1;
    step();
    bus_a.mem_ready = 1'b1; step();
    bus_a.Op = {6'b000101, 5'($urandom)}; step();
    chk("aux_b_illegal", {bus_a.illegal_op, bus_a.bus_err}, 2'b10);
    chk("aux_b_no_uncond", ctrl_a(), 14'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
